// File: rtl/noc_pkg.sv
// noc_pkg: shared port indices, crossbar select encoding and allocator state type
package noc_pkg;
    localparam int NUM_PORTS = 5;
    typedef enum logic [2:0] {PORT_N = 3'd0, PORT_S, PORT_E, PORT_W, PORT_L} port_e;
    localparam logic [2:0] PORT_SEL_NONE = 3'b111;
    typedef enum logic [1:0] {IDLE, ACTIVE, STALL} alloc_state_e;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational rotating-priority search, first eligible index at or after ptr_i
module rr_picker #(
    parameter int N  = 5,
    parameter int IW = 3
) (
    input  logic [N-1:0]  elig_i,
    input  logic [IW-1:0] ptr_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);
    localparam logic [IW:0] NL = (IW + 1)'(N);
    logic [N-1:0]  rot;
    logic [IW-1:0] off;
    logic [IW:0]   sum;
    // rotate so ptr_i lands on bit 0, take the lowest set bit, then rotate the offset back
    always_comb begin
        rot = N'({elig_i, elig_i} >> ptr_i);
        off = '0;
        for (int o = N - 1; o >= 0; o--) off = rot[o] ? IW'(o) : off;
        sum = {1'b0, ptr_i} + {1'b0, off};
        valid_o = |elig_i;
        idx_o = (sum >= NL) ? IW'(sum - NL) : IW'(sum);
    end
endmodule

// File: rtl/port_allocator.sv
// port_allocator: credit-gated round-robin output port allocator (optional grant counter: PORT_ALLOC_STATS_EN)
module port_allocator
    import noc_pkg::*;
#(
    parameter int NUM_REQ      = NUM_PORTS,
    parameter int CREDIT_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_i,
    input  logic                              credit_inc_i,
    output logic [NUM_REQ-1:0]                grant_o,
    output logic [NUM_REQ-1:0]                pop_o,
    output logic [2:0]                        port_sel_o,
    output logic                              send_en_o,
    output logic                              full_o,
    output logic [$clog2(CREDIT_DEPTH+1)-1:0] credits_o,
    output logic [15:0]                       stat_sent_o
);
    localparam int CW = $clog2(CREDIT_DEPTH + 1);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    logic [NUM_REQ-1:0] grant_q, grant_d, elig;
    logic [2:0]         sel_q, sel_d;
    logic [CW-1:0]      credits_q, credits_d;
    logic [IW-1:0]      rr_q, rr_d, pick_idx;
    logic               pick_valid, started_q, gnt;
    alloc_state_e       state_q, state_d;

    // a head already popped this cycle must not be granted again
    assign elig = req_i & ~grant_q;

    rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
        .elig_i (elig),
        .ptr_i  (rr_q),
        .valid_o(pick_valid),
        .idx_o  (pick_idx)
    );

    // a credit returning this edge may be spent immediately; the first edge after reset never grants
    assign gnt = pick_valid && started_q && (credits_q != '0 || credit_inc_i);

    // next-state: grant, select, pointer, credits and FSM state
    always_comb begin
        grant_d   = gnt ? NUM_REQ'(1) << pick_idx : '0;
        sel_d     = gnt ? 3'(pick_idx) : PORT_SEL_NONE;
        rr_d      = !gnt ? rr_q : (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
        credits_d = (credit_inc_i && !gnt && credits_q == CW'(CREDIT_DEPTH)) ? credits_q
                  : credits_q + CW'(credit_inc_i) - CW'(gnt);
        state_d   = gnt ? ACTIVE : (|elig && credits_q == '0) ? STALL : IDLE;
    end

    // state registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_q   <= '0;
            sel_q     <= PORT_SEL_NONE;
            credits_q <= CW'(CREDIT_DEPTH);
            rr_q      <= '0;
            started_q <= 1'b0;
            state_q   <= IDLE;
        end else begin
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            credits_q <= credits_d;
            rr_q      <= rr_d;
            started_q <= 1'b1;
            state_q   <= state_d;
        end
    end

`ifdef PORT_ALLOC_STATS_EN
    logic [15:0] stat_q;
    // saturating count of issued grants
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stat_q <= '0;
        else      stat_q <= (gnt && stat_q != 16'hFFFF) ? stat_q + 16'd1 : stat_q;
    end
    assign stat_sent_o = stat_q;
`else
    assign stat_sent_o = '0;
`endif

    assign grant_o    = grant_q;
    assign pop_o      = grant_q;
    assign port_sel_o = sel_q;
    assign send_en_o  = (state_q == ACTIVE);
    assign full_o     = (credits_q == '0);
    assign credits_o  = credits_q;
endmodule

// File: tb/tb_port_allocator.sv
// tb_port_allocator: randomized and directed checks of port_allocator against a behavioural model
module tb_port_allocator;
    localparam int N = 5;
    localparam int D = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  req_i = '0;
    logic        credit_inc_i = 1'b0;
    logic [4:0]  grant_o, pop_o;
    logic [2:0]  port_sel_o;
    logic        send_en_o, full_o;
    logic [2:0]  credits_o;
    logic [15:0] stat_sent_o;
    int checks = 0;
    int failures = 0;
    int m_credits, m_rr, m_pop, m_win, m_stat;
    bit m_started;

    port_allocator #(.NUM_REQ(N), .CREDIT_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .credit_inc_i(credit_inc_i),
        .grant_o(grant_o), .pop_o(pop_o), .port_sel_o(port_sel_o), .send_en_o(send_en_o),
        .full_o(full_o), .credits_o(credits_o), .stat_sent_o(stat_sent_o)
    );

    always #5 clk = ~clk;

    wire [33:0] dut_vec = {grant_o, pop_o, port_sel_o, send_en_o, full_o, credits_o, stat_sent_o};

    function automatic void model_reset();
        m_credits = D; m_rr = 0; m_pop = -1; m_win = -1; m_stat = 0; m_started = 0;
    endfunction

    // one clock edge of the allocator's behaviour, written from the arbitration rules
    function automatic void model_step(input logic [4:0] req, input logic inc);
        m_win = -1;
        if (m_started && (m_credits > 0 || inc))
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_rr + k) % N;
                if (m_win < 0 && req[j] && j != m_pop) m_win = j;
            end
        m_credits = m_credits + int'(inc) - ((m_win >= 0) ? 1 : 0);
        if (m_credits > D) m_credits = D;
        if (m_win >= 0) m_rr = (m_win + 1) % N;
        m_pop = m_win;
        m_started = 1;
`ifdef PORT_ALLOC_STATS_EN
        if (m_win >= 0 && m_stat < 65535) m_stat++;
`endif
    endfunction

    function automatic logic [33:0] exp_vec();
        logic [4:0] g;
        g = (m_win >= 0) ? 5'(1 << m_win) : 5'd0;
        return {g, g, (m_win >= 0) ? 3'(m_win) : 3'b111, m_win >= 0, m_credits == 0, 3'(m_credits), 16'(m_stat)};
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        req_i = '0;
        credit_inc_i = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec !== exp_vec()) begin failures++; $display("FAIL reset_async: got %h want %h", dut_vec, exp_vec()); end
        req_i = 5'b11111;
        credit_inc_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (dut_vec !== exp_vec()) begin failures++; $display("FAIL reset_hold: got %h want %h", dut_vec, exp_vec()); end
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            model_step(req_i, credit_inc_i);
            @(posedge clk); #1;
            checks++;
            if (dut_vec !== exp_vec()) begin failures++; $display("FAIL reset_release c%0d: got %h want %h", i, dut_vec, exp_vec()); end
            if (i == 1) begin
                checks++;
                if (grant_o !== 5'b00001) begin failures++; $display("FAIL first_grant_edge2: got %b want 00001", grant_o); end
            end
        end
    endtask

    task automatic test_alternate();
        logic [4:0] prev;
        do_reset();
        prev = '0;
        for (int i = 0; i < 10; i++) begin
            req_i = 5'b10001; credit_inc_i = 1'b1;
            model_step(req_i, credit_inc_i);
            @(posedge clk); #1;
            checks++;
            if (dut_vec !== exp_vec()) begin failures++; $display("FAIL alternate c%0d: got %h want %h", i, dut_vec, exp_vec()); end
            checks++;
            if ((prev & grant_o) !== 5'b0) begin failures++; $display("FAIL alternate_repeat c%0d: got %b after %b want disjoint", i, grant_o, prev); end
            prev = grant_o;
        end
    endtask

    task automatic test_round_robin();
        int order[6] = '{0, 1, 2, 3, 4, 0};
        int n;
        do_reset();
        n = 0;
        for (int i = 0; i < 7; i++) begin
            req_i = 5'b11111; credit_inc_i = 1'b1;
            model_step(req_i, credit_inc_i);
            @(posedge clk); #1;
            checks++;
            if (dut_vec !== exp_vec()) begin failures++; $display("FAIL round_robin c%0d: got %h want %h", i, dut_vec, exp_vec()); end
            if (send_en_o === 1'b1 && n < 6) begin
                checks++;
                if (int'(port_sel_o) != order[n]) begin failures++; $display("FAIL rr_order #%0d: got %0d want %0d", n, port_sel_o, order[n]); end
                n++;
            end
        end
        checks++;
        if (n != 6 || credits_o !== 3'd4) begin failures++; $display("FAIL rr_summary: got grants=%0d credits=%0d want 6/4", n, credits_o); end
    endtask

    task automatic test_stall();
        int n;
        do_reset();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            req_i = 5'b00100; credit_inc_i = 1'b0;
            model_step(req_i, credit_inc_i);
            @(posedge clk); #1;
            checks++;
            if (dut_vec !== exp_vec()) begin failures++; $display("FAIL stall c%0d: got %h want %h", i, dut_vec, exp_vec()); end
            if (send_en_o === 1'b1) n++;
        end
        checks++;
        if (n != 4 || full_o !== 1'b1 || send_en_o !== 1'b0) begin
            failures++; $display("FAIL stall_state: got grants=%0d full=%b send=%b want 4/1/0", n, full_o, send_en_o);
        end
        credit_inc_i = 1'b1;
        model_step(req_i, credit_inc_i);
        @(posedge clk); #1;
        checks++;
        if (grant_o !== 5'b00100 || credits_o !== 3'd0) begin
            failures++; $display("FAIL stall_wake: got grant=%b credits=%0d want 00100/0", grant_o, credits_o);
        end
        for (int i = 0; i < 3; i++) begin
            credit_inc_i = 1'b0;
            model_step(req_i, credit_inc_i);
            @(posedge clk); #1;
            checks++;
            if (dut_vec !== exp_vec()) begin failures++; $display("FAIL stall_after c%0d: got %h want %h", i, dut_vec, exp_vec()); end
        end
    endtask

    task automatic test_credit_saturate();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            req_i = '0; credit_inc_i = 1'b1;
            model_step(req_i, credit_inc_i);
            @(posedge clk); #1;
            checks++;
            if (credits_o !== 3'd4 || dut_vec !== exp_vec()) begin failures++; $display("FAIL credit_sat c%0d: got %h want %h", i, dut_vec, exp_vec()); end
        end
    endtask

    task automatic test_async_reset();
        int waited;
        do_reset();
        req_i = 5'b00010;
        waited = 0;
        while (grant_o !== 5'b00010 && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        checks++;
        if (grant_o !== 5'b00010) begin failures++; $display("FAIL midburst_grant: got %b want 00010", grant_o); end
        #2 rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec !== exp_vec()) begin failures++; $display("FAIL midburst_clear: got %h want %h", dut_vec, exp_vec()); end
        @(posedge clk); #1;
        rst = 1'b1;
        req_i = 5'b11111;
        for (int i = 0; i < 3; i++) begin
            model_step(req_i, credit_inc_i);
            @(posedge clk); #1;
            checks++;
            if (dut_vec !== exp_vec()) begin failures++; $display("FAIL post_reset c%0d: got %h want %h", i, dut_vec, exp_vec()); end
            if (i == 1) begin
                checks++;
                if (grant_o !== 5'b00001 || credits_o !== 3'd3) begin failures++; $display("FAIL post_reset_first: got %b/%0d want 00001/3", grant_o, credits_o); end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req_i = 5'($urandom);
            credit_inc_i = ($urandom_range(0, 2) == 0);
            model_step(req_i, credit_inc_i);
            @(posedge clk); #1;
            checks++;
            if (dut_vec !== exp_vec()) begin failures++; $display("FAIL random c%0d: got %h want %h", i, dut_vec, exp_vec()); end
        end
    endtask

    task automatic test_stats();
`ifdef PORT_ALLOC_STATS_EN
        do_reset();
        for (int i = 0; i < 70001; i++) begin
            req_i = 5'b11111; credit_inc_i = 1'b1;
            model_step(req_i, credit_inc_i);
            @(posedge clk); #1;
        end
        checks++;
        if (stat_sent_o !== 16'hFFFF || dut_vec !== exp_vec()) begin failures++; $display("FAIL stat_saturate: got %h want ffff", stat_sent_o); end
`else
        checks++;
        if (stat_sent_o !== 16'h0) begin failures++; $display("FAIL stat_disabled: got %h want 0", stat_sent_o); end
`endif
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_round_robin();
        test_stall();
        test_credit_saturate();
        test_async_reset();
        test_random();
        test_stats();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/port_allocator.md
PORT_ALLOCATOR -- requirements
Module: port_allocator

Interface
REQ-001 SHALL have parameter NUM_REQ, default 5, meaning number of requesting input ports (N,S,E,W,L).
REQ-002 SHALL have parameter CREDIT_DEPTH, default 4, meaning downstream buffer slots (credits at reset).
REQ-003 SHALL have one clock and one reset: clk and rst; reset is asynchronous and active-low.
REQ-004 SHALL have ports:
- clk  in  1  clock
- rst  in  1  async active-low reset
- req_i  in  NUM_REQ  bit i = input port i has a valid head flit destined for this output
- credit_inc_i  in  1  downstream freed one slot
- grant_o  out  NUM_REQ  one-hot grant, registered
- pop_o  out  NUM_REQ  remove head flit of granted input (equals grant_o)
- port_sel_o  out  3  crossbar select: index of granted input, 3'b111 = none
- send_en_o  out  1  output port write enable
- full_o  out  1  credits == 0
- credits_o  out  $clog2(CREDIT_DEPTH+1)  current credit count
- stat_sent_o  out  16  flits sent (see Configuration)

Function
REQ-005 SHALL arbitrate at each rising clk edge among eligible requesters; results appear on registered outputs the following cycle (latency 1).
REQ-006 SHALL treat requester i as eligible iff req_i[i]=1 and pop_o[i]=0 in the current cycle (head not yet removed; prevents double grant).
REQ-007 SHALL pick the first eligible requester at or after rr_ptr, wrapping NUM_REQ-1 -> 0.
REQ-008 SHALL, on a grant to index k, set rr_ptr to (k+1) mod NUM_REQ; rr_ptr SHALL hold when nothing is granted.
REQ-009 SHALL grant only when credits > 0; send_en_o SHALL equal |grant_o; port_sel_o SHALL equal k when granting, else 3'b111.
REQ-010 SHALL decrement credits on each grant and increment on credit_inc_i; both in one cycle -> unchanged.
REQ-011 SHALL saturate credits at CREDIT_DEPTH (extra credit_inc_i ignored) and never underflow.
REQ-012 SHALL run FSM {IDLE, ACTIVE, STALL}: IDLE = no grant issued; ACTIVE = grant issued this edge; STALL = eligible request pending with credits == 0.
REQ-013 SHALL transition STALL -> ACTIVE on the first edge where credits > 0 (including a credit arriving that edge), granting the rr_ptr-ordered winner.
REQ-014 SHALL produce one grant per cycle maximum; back-to-back grants to different requesters SHALL be allowed.

Reset
REQ-015 SHALL on rst=0 immediately force grant_o=0, pop_o=0, send_en_o=0, port_sel_o=3'b111, credits=CREDIT_DEPTH, full_o=0, rr_ptr=0, state=IDLE, stat_sent_o=0.
REQ-016 SHALL discard any in-flight grant when reset asserts mid-operation; the first grant is issued on the second rising edge after rst deasserts.

Configuration
REQ-017 SHALL, with macro PORT_ALLOC_STATS_EN defined, count grants in a 16-bit saturating counter (holds at 16'hFFFF) driven on stat_sent_o.
REQ-018 SHALL, without PORT_ALLOC_STATS_EN, omit the counter and tie stat_sent_o to 0.

Structure
REQ-019 SHALL take NUM_PORTS, the port index enum (N=0,S=1,E=2,W=3,L=4), and PORT_SEL_NONE (3'b111) from shared package noc_pkg.
REQ-020 SHALL place the rotating priority search in one combinational sub-module rr_picker (inputs: eligible vector, rr_ptr; outputs: grant valid, index).

Verification
REQ-021 Reset, then req_i=5'b10001 held -> grants alternate L? no: N (idx0) then L (idx4) then N; each pop_o one cycle wide, never the same index on consecutive cycles.
REQ-022 req_i=5'b11111 held, credit_inc_i pulsed each granted cycle -> grant order 0,1,2,3,4,0; credits stays 4.
REQ-023 req_i=5'b00100, no credit_inc_i -> exactly 4 grants, then full_o=1, state STALL, send_en_o=0; one credit_inc_i pulse -> exactly one further grant next edge.
REQ-024 credits=0, credit_inc_i=1 and request pending same cycle -> grant on that edge, credits remains 0; at credits=4 an extra credit_inc_i -> credits remains 4.
REQ-025 Assert rst mid-burst with grant_o=5'b00010 -> outputs cleared asynchronously before next edge; after release, credits_o=4, first grant to lowest eligible index.
REQ-026 With PORT_ALLOC_STATS_EN, 70000 grants -> stat_sent_o=16'hFFFF; without it -> stat_sent_o=0.
